// File: rtl/wb_wait_state_mem_pkg.sv
// rtl/wb_wait_state_mem_pkg.sv - shared types and constants for the wait-state Wishbone memory
package wb_wait_state_mem_pkg;

  localparam int WB_DAT_W = 32;
  localparam int WB_SEL_W = 4;
  // Wide enough for the largest supported wait-state count (15).
  localparam int CNT_W    = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_e;

endpackage

// File: rtl/wb_sel_ram.sv
// rtl/wb_sel_ram.sv - word array with per-byte write enables and a registered read port
module wb_sel_ram
  import wb_wait_state_mem_pkg::*;
#(
  parameter int DEPTH = 1024,
  parameter int AW    = 10
) (
  input  logic                clk,
  input  logic                we_i,
  input  logic                re_i,
  input  logic [AW-1:0]       addr_i,
  input  logic [WB_SEL_W-1:0] sel_i,
  input  logic [WB_DAT_W-1:0] wdata_i,
  output logic [WB_DAT_W-1:0] rdata_o
);

  logic [WB_DAT_W-1:0] mem_q [DEPTH];
  logic [WB_DAT_W-1:0] rdata_q;

  // No reset here so the array and read register can map onto block RAM.
  always_ff @(posedge clk) begin
    if (we_i) begin
      for (int b = 0; b < WB_SEL_W; b++) begin
        if (sel_i[b]) begin
          mem_q[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
        end
      end
    end
    if (re_i) begin
      rdata_q <= mem_q[addr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/wb_wait_state_mem.sv
// rtl/wb_wait_state_mem.sv - Wishbone B4 pipelined responder memory with configurable wait states
module wb_wait_state_mem
  import wb_wait_state_mem_pkg::*;
#(
  parameter int DEPTH       = 1024,
  parameter int WAIT_STATES = 0,
  parameter int ADR_W       = 28
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                i_wb_cyc,
  input  logic                i_wb_stb,
  input  logic                i_wb_we,
  input  logic [ADR_W-1:0]    i_wb_adr,
  input  logic [WB_SEL_W-1:0] i_wb_sel,
  input  logic [WB_DAT_W-1:0] i_wb_dat,
  output logic [WB_DAT_W-1:0] o_wb_dat,
  output logic                o_wb_ack,
  output logic                o_wb_err,
  output logic                o_wb_stall
);

  localparam int              AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADR_W:0]  DEPTH_L = (ADR_W+1)'(DEPTH);
  localparam logic [CNT_W-1:0] WS_L   = CNT_W'(WAIT_STATES);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               err_q, err_d;
  logic               rd_q, rd_d;

  logic               stall;
  logic               accept;
  logic               in_range;
  logic               resp_live;
  logic [WB_DAT_W-1:0] ram_rdata;

  assign stall    = (state_q == ST_WAIT);
  assign accept   = i_wb_cyc & i_wb_stb & ~stall;
  assign in_range = ({1'b0, i_wb_adr} < DEPTH_L);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    rd_d    = rd_q;
    case (state_q)
      ST_WAIT: begin
        if (!i_wb_cyc) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else if (cnt_q <= CNT_W'(1)) begin
          state_d = ST_RESP;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      // IDLE and RESP share acceptance handling; RESP falls back to IDLE when nothing new arrives.
      default: begin
        state_d = ST_IDLE;
        if (accept) begin
          err_d = ~in_range;
          rd_d  = ~i_wb_we;
          if (WAIT_STATES == 0) begin
            state_d = ST_RESP;
          end else begin
            state_d = ST_WAIT;
            cnt_d   = WS_L;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      rd_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      rd_q    <= rd_d;
    end
  end

  wb_sel_ram #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .clk     (clk),
    .we_i    (accept & i_wb_we & in_range),
    .re_i    (accept & ~i_wb_we & in_range),
    .addr_i  (i_wb_adr[AW-1:0]),
    .sel_i   (i_wb_sel),
    .wdata_i (i_wb_dat),
    .rdata_o (ram_rdata)
  );

  // Dropping cyc in the response cycle suppresses the completion as an abort.
  assign resp_live  = (state_q == ST_RESP) & i_wb_cyc;
  assign o_wb_ack   = resp_live & ~err_q;
  assign o_wb_err   = resp_live & err_q;
  assign o_wb_stall = stall;
  assign o_wb_dat   = (o_wb_ack & rd_q) ? ram_rdata : '0;

endmodule

// File: doc/wb_wait_state_mem.md
# wb_wait_state_mem

Wishbone B4 pipelined responder: a word-addressed, byte-enabled 32-bit memory with a configurable number of wait states. It is the slave end of the instruction and data buses driven by the Ibex Wishbone core. It serves as a bring-up and verification target for those buses, and as a model of slow peripherals that exercise the core's stall/ack handling.

## Interface
- `DEPTH`, 1024: memory size in 32-bit words. Valid word indices are 0..DEPTH-1.
- `WAIT_STATES`, 0: extra cycles between request acceptance and response. Range 0..15.
- `ADR_W`, 28: word-address width, matching the core's bus address width.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: reset, **asynchronous, active-low**.
- `i_wb_cyc` in 1: bus cycle active.
- `i_wb_stb` in 1: request strobe.
- `i_wb_we` in 1: 1 = write, 0 = read.
- `i_wb_adr` in ADR_W: word address.
- `i_wb_sel` in 4: byte enables. Bit n covers data bits [8n+7:8n].
- `i_wb_dat` in 32: write data.
- `o_wb_dat` out 32: read data.
- `o_wb_ack` out 1: successful completion, one-cycle pulse.
- `o_wb_err` out 1: error completion, one-cycle pulse.
- `o_wb_stall` out 1: request cannot be accepted this cycle.

## Operation
- **Acceptance:** a request is accepted in a cycle when `i_wb_cyc & i_wb_stb & ~o_wb_stall`. A request presented while stalled is ignored; the master holds it.
- **Outstanding limit:** at most one accepted request is outstanding.
- **Range check:** a request is in range when `i_wb_adr < DEPTH`. Out-of-range requests cause no memory side effect and complete with `o_wb_err` instead of `o_wb_ack`.
- **Write:** an in-range write updates the selected bytes at the acceptance clock edge. Unselected bytes are unchanged. `sel=0` is a legal no-op write that still acks.
- **Read:** an in-range read captures the word at the acceptance edge. It returns all 4 bytes regardless of `sel`.
- **FSM:** states IDLE, WAIT, RESP.
  - IDLE: on acceptance, go to RESP if WAIT_STATES=0; otherwise load the counter with WAIT_STATES and go to WAIT.
  - WAIT: decrement the counter each cycle. When it reaches 1, go to RESP.
  - RESP: drive `ack` or `err` for this cycle. A new acceptance in the same cycle follows the IDLE rules; otherwise go to IDLE.
- **Abort:** `i_wb_cyc` low in WAIT or RESP aborts the transaction.
  - Next state is IDLE, and no `ack`/`err` is driven in that cycle.
  - A write already performed stays performed.
- `ack` and `err` are never high together.

## Timing
- **Reset:** FSM IDLE, counter 0, `o_wb_ack=0`, `o_wb_err=0`, `o_wb_stall=0`, `o_wb_dat=0`. Memory contents are not reset.
- **Latency:** request accepted in cycle t → `ack`/`err` in cycle t+1+WAIT_STATES.
- **Stall:** `o_wb_stall=1` exactly in WAIT. It is low in IDLE and RESP, so a new request may be accepted in the response cycle.
- **Throughput:** one transaction per WAIT_STATES+1 cycles. With WAIT_STATES=0, stall never asserts and there is one transaction per cycle, back-to-back.
- **Read data:** `o_wb_dat` holds the captured word only in an `ack` cycle of a read. It is 0 in all other cycles, including `err` cycles.
- **Read-after-write:** a read accepted the cycle after a write to the same address returns the new data.
- **Reset mid-transaction:** all outputs return to reset values immediately, asynchronously. No response is issued.

## Structure
- Package `wb_wait_state_mem_pkg` holds:
  - the state enum (IDLE, WAIT, RESP);
  - the constant `WB_DAT_W=32`;
  - the constant `WB_SEL_W=4`.
- Sub-module `wb_sel_ram`: DEPTH×32 register array with per-byte write enable and a registered read port. It is kept separate so an inferred BRAM can replace it.
- The top level contains the FSM, counter, range check and output registers.

## Test plan
- **Single write/read, WAIT_STATES=0:** write 0xDEADBEEF to addr 5 with sel=0xF, then read addr 5. Each is acked one cycle after acceptance; the read returns 0xDEADBEEF; stall is never high.
- **Byte enables:** write 0x11223344 with sel=0xF, then 0xAABBCCDD with sel=0x5, then read. The read returns 0x11BB33DD.
- **WAIT_STATES=3 streaming:** 4 back-to-back reads. Stall is high 3 cycles after each acceptance; each ack comes 4 cycles after its acceptance; the 4 acks are 4 cycles apart.
- **Out of range, DEPTH=1024:** write then read at addr 1024. `err` pulses at the normal latency with `ack=0` and `o_wb_dat=0`; a read of addr 0 shows it was not corrupted.
- **Abort, WAIT_STATES=3:** drop `i_wb_cyc` one cycle after a write is accepted. No `ack`/`err` is issued; stall goes low the next cycle; a later read shows the write took effect.
- **Async reset:** assert `rst_n=0` in WAIT. All outputs are 0 before the next clock edge; after release the first new request completes normally.
